// File: rtl/unpack_u32_stream.sv
// Streaming unsigned-LEB128 decoder: one byte per cycle in, one registered W-bit word out.
// Optional overflow detection and resync is enabled with `define LEB128_OVERFLOW_CHECK_EN.
module unpack_u32_stream #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   i_data,
   input  logic         i_valid,
   output logic         i_ready,
   output logic [W-1:0] o_data,
   output logic [2:0]   o_len,
   output logic         o_err,
   output logic         o_valid,
   input  logic         o_ready
);

   localparam int MAXB = (W + 6) / 7;

   logic [W-1:0] acc;
   logic [W-1:0] acc_next;
   logic [W-1:0] chunk;
   logic [2:0]   cnt;
   logic         last_byte;
   logic         is_final;
   logic         accept;

`ifdef LEB128_OVERFLOW_CHECK_EN
   localparam logic [0:0] ST_ACC    = 1'b0;
   localparam logic [0:0] ST_RESYNC = 1'b1;
   // Payload bits of the last byte that fall above bit W-1.
   localparam int         LASTBITS  = W - 7 * (MAXB - 1);
   localparam logic [6:0] XMASK     = 7'(7'h7F << LASTBITS);

   logic [0:0] state;
   logic       word_err;

   assign i_ready  = (state == ST_RESYNC) | ~o_valid | o_ready;
   assign word_err = last_byte & (i_data[7] | ((i_data[6:0] & XMASK) != 7'd0));
`else
   assign i_ready  = ~o_valid | o_ready;
   assign o_err    = 1'b0;
`endif

   assign accept    = i_valid & i_ready;
   assign chunk     = W'(i_data[6:0]);
   assign acc_next  = acc | (chunk << (7 * cnt));
   assign last_byte = (cnt == 3'(MAXB - 1));
   assign is_final  = ~i_data[7] | last_byte;

   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_len   <= '0;
         acc     <= '0;
         cnt     <= '0;
`ifdef LEB128_OVERFLOW_CHECK_EN
         o_err   <= 1'b0;
         state   <= ST_ACC;
`endif
      end else begin
         if (o_valid & o_ready)
            o_valid <= 1'b0;
`ifdef LEB128_OVERFLOW_CHECK_EN
         if (accept && state == ST_RESYNC) begin
            if (!i_data[7])
               state <= ST_ACC;
         end else if (accept) begin
`else
         if (accept) begin
`endif
            if (is_final) begin
               o_data  <= acc_next;
               o_len   <= cnt + 3'd1;
               o_valid <= 1'b1;
               acc     <= '0;
               cnt     <= '0;
`ifdef LEB128_OVERFLOW_CHECK_EN
               o_err   <= word_err;
               if (last_byte && i_data[7])
                  state <= ST_RESYNC;
`endif
            end else begin
               acc <= acc_next;
               cnt <= cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_unpack_u32_stream.sv
// Scoreboard bench for unpack_u32_stream: directed LEB128 byte streams, expected words queued.
// Expectations follow LEB128_OVERFLOW_CHECK_EN when defined.
module tb_unpack_u32_stream;

   typedef struct packed {
      logic [31:0] d;
      logic [2:0]  l;
      logic        e;
   } word_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  i_data;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] o_data;
   logic [2:0]  o_len;
   logic        o_err;
   logic        o_valid;
   logic        o_ready;

   int unsigned npass = 0;
   int unsigned ntot  = 0;
   int unsigned cyc   = 0;
   word_t       expq[$];

   unpack_u32_stream #(.W(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_len   (o_len),
      .o_err   (o_err),
      .o_valid (o_valid),
      .o_ready (o_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (ok) npass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [31:0] d, input logic [2:0] l, input logic e);
      word_t w;
      w.d = d; w.l = l; w.e = e;
      expq.push_back(w);
   endtask

   // Monitor: a handshake seen at negedge completes on the following posedge.
   always @(negedge clk) begin
      if (!reset && o_valid && o_ready) begin
         word_t act;
         act = {o_data, o_len, o_err};
         if (expq.size() == 0) begin
            check(1'b0, "unexpected_word", 64'(act), 64'd0);
         end else begin
            word_t exp;
            exp = expq.pop_front();
            check(act == exp, "word", 64'(act), 64'(exp));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int unsigned n = 0;
      i_data  = b;
      i_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (i_ready) break;
         n++;
         if (n > 200) begin
            check(1'b0, "send_timeout", 64'(b), 64'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   initial begin
      int unsigned t0;
      reset   = 1'b1;
      o_ready = 1'b1;
      i_valid = 1'b0;
      i_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check(o_valid == 1'b0, "rst_valid", 64'(o_valid), 64'd0);
      check(o_data == 32'd0, "rst_data", 64'(o_data), 64'd0);
      check(o_len == 3'd0, "rst_len", 64'(o_len), 64'd0);
      check(o_err == 1'b0, "rst_err", 64'(o_err), 64'd0);
      check(i_ready == 1'b1, "rst_iready", 64'(i_ready), 64'd1);
      @(posedge clk);
      #1;

      // Single-byte zero: o_valid the cycle after acceptance
      push(32'd0, 3'd1, 1'b0);
      send_byte(8'h00);
      check(o_valid == 1'b1, "latency", 64'(o_valid), 64'd1);

      push(32'h00098765, 3'd3, 1'b0);
      send_byte(8'hE5); send_byte(8'h8E); send_byte(8'h26);

      push(32'hFFFFFFFF, 3'd5, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'hFF);
      send_byte(8'h0F);

`ifdef LEB128_OVERFLOW_CHECK_EN
      push(32'hFFFFFFFF, 3'd5, 1'b1);
      push(32'd5, 3'd1, 1'b0);
`else
      push(32'hFFFFFFFF, 3'd5, 1'b0);
      push(32'd1, 3'd1, 1'b0);
      push(32'd5, 3'd1, 1'b0);
`endif
      for (int i = 0; i < 4; i++) send_byte(8'hFF);
      send_byte(8'h9F); send_byte(8'h01); send_byte(8'h05);

      // Excess payload bits on a terminating 5th byte
`ifdef LEB128_OVERFLOW_CHECK_EN
      push(32'hFFFFFFFF, 3'd5, 1'b1);
`else
      push(32'hFFFFFFFF, 3'd5, 1'b0);
`endif
      for (int i = 0; i < 4; i++) send_byte(8'hFF);
      send_byte(8'h1F);

      // Non-minimal encoding of zero
      push(32'd0, 3'd2, 1'b0);
      send_byte(8'h80); send_byte(8'h00);

      // Back-to-back single-byte words at one per cycle
      push(32'h7F, 3'd1, 1'b0);
      push(32'h00, 3'd1, 1'b0);
      push(32'h2A, 3'd1, 1'b0);
      t0 = cyc;
      send_byte(8'h7F); send_byte(8'h00); send_byte(8'h2A);
      check(cyc - t0 == 3, "b2b_cycles", 64'(cyc - t0), 64'd3);

      // Backpressure: first word held, input stalled
      @(posedge clk);
      #1;
      o_ready = 1'b0;
      push(32'd1, 3'd1, 1'b0);
      push(32'd2, 3'd1, 1'b0);
      push(32'd3, 3'd1, 1'b0);
      send_byte(8'h01);
      fork
         begin
            send_byte(8'h02);
            send_byte(8'h03);
         end
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               check(o_valid && o_data == 32'd1 && o_len == 3'd1,
                     "hold_data", 64'({o_valid, o_data}), 64'({1'b1, 32'd1}));
               check(i_ready == 1'b0, "hold_iready", 64'(i_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            o_ready = 1'b1;
         end
      join

      // Reset mid-word discards the partial word
      send_byte(8'h80); send_byte(8'h80);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check(o_valid == 1'b0, "midword_rst_valid", 64'(o_valid), 64'd0);
      push(32'd5, 3'd1, 1'b0);
      send_byte(8'h05);

      for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      check(expq.size() == 0, "drain", 64'(expq.size()), 64'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
